// File: rtl/empty_ptr_storage.sv
// Free-address allocator for the data table: presents one free address at a time,
// recycles released addresses through a FIFO and serves untouched addresses from a counter.
module empty_ptr_storage #(
   parameter int A_WIDTH = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   output logic [A_WIDTH-1:0] empty_addr_o,
   output logic               empty_addr_val_o,
   input  logic               empty_addr_rd_ack_i,
   input  logic [A_WIDTH-1:0] add_empty_ptr_i,
   input  logic               add_empty_ptr_en_i,
   output logic [A_WIDTH:0]   free_cnt_o,
   output logic               err_ack_no_val_o,
   output logic               err_overflow_o
);

   localparam int             DEPTH   = 2 ** A_WIDTH;
   localparam logic [A_WIDTH:0] DEPTH_W = (A_WIDTH + 1)'(DEPTH);

   logic [A_WIDTH-1:0] out_addr_q, out_addr_d;
   logic               out_val_q, out_val_d;
   logic [A_WIDTH:0]   fresh_cnt_q, fresh_cnt_d;
   logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [A_WIDTH:0]   fifo_cnt_q, fifo_cnt_d;
   logic               err_ack_q, err_ack_d;
   logic               err_ovf_q, err_ovf_d;
   logic [A_WIDTH-1:0] mem_q [DEPTH];

   logic               ack_ok;
   logic               add_ok;
   logic               fifo_rd;
   logic               fresh_rd;
   logic [A_WIDTH:0]   free_cnt;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      out_addr_d  = out_addr_q;
      out_val_d   = out_val_q;
      fresh_cnt_d = fresh_cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fifo_cnt_d  = fifo_cnt_q;

      free_cnt = fifo_cnt_q + (DEPTH_W - fresh_cnt_q) + {{A_WIDTH{1'b0}}, out_val_q};
      ack_ok   = empty_addr_rd_ack_i && out_val_q;
      add_ok   = add_empty_ptr_en_i && (free_cnt != DEPTH_W);
      // Refill looks only at pre-edge state: an add in the same edge is served next time.
      fifo_rd  = !out_val_q && (fifo_cnt_q != '0);
      fresh_rd = !out_val_q && (fifo_cnt_q == '0) && (fresh_cnt_q != DEPTH_W);

      if (fifo_rd) begin
         out_addr_d = mem_q[rd_ptr_q];
         out_val_d  = 1'b1;
         rd_ptr_d   = rd_ptr_q + A_WIDTH'(1);
      end else if (fresh_rd) begin
         out_addr_d  = fresh_cnt_q[A_WIDTH-1:0];
         out_val_d   = 1'b1;
         fresh_cnt_d = fresh_cnt_q + (A_WIDTH + 1)'(1);
      end else if (ack_ok) begin
         out_val_d = 1'b0;
      end

      if (add_ok) begin
         wr_ptr_d = wr_ptr_q + A_WIDTH'(1);
      end

      case ({add_ok, fifo_rd})
         2'b10:   fifo_cnt_d = fifo_cnt_q + (A_WIDTH + 1)'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - (A_WIDTH + 1)'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase

      err_ack_d = err_ack_q || (empty_addr_rd_ack_i && !out_val_q);
      err_ovf_d = err_ovf_q || (add_empty_ptr_en_i && !add_ok);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_addr_q  <= '0;
         out_val_q   <= 1'b0;
         fresh_cnt_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         err_ack_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         out_addr_q  <= out_addr_d;
         out_val_q   <= out_val_d;
         fresh_cnt_q <= fresh_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         err_ack_q   <= err_ack_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   // NOTE: the FIFO storage has no reset; fifo_cnt guards every read so stale entries are never used.
   always_ff @(posedge clk_i) begin
      if (add_ok) begin
         mem_q[wr_ptr_q] <= add_empty_ptr_i;
      end
   end

   assign empty_addr_o     = out_addr_q;
   assign empty_addr_val_o = out_val_q;
   assign free_cnt_o       = free_cnt;
   assign err_ack_no_val_o = err_ack_q;
   assign err_overflow_o   = err_ovf_q;

endmodule
